// File: rtl/int_to_float.sv
// int_to_float: converts a 32-bit two's-complement integer into an IEEE-754
// single-precision value using a multi-cycle state machine with stb/ack
// handshakes. Normalisation shifts one bit per cycle and rounding is
// round-to-nearest, ties-to-even.
`timescale 1ns/1ps
module int_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    localparam logic [2:0] GET_A     = 3'd0;
    localparam logic [2:0] CONVERT_0 = 3'd1;
    localparam logic [2:0] NORMALISE = 3'd2;
    localparam logic [2:0] EXTRACT   = 3'd3;
    localparam logic [2:0] ROUND     = 3'd4;
    localparam logic [2:0] PACK      = 3'd5;
    localparam logic [2:0] PUT_Z     = 3'd6;

    logic [2:0]  state_q,  state_d;
    logic [31:0] a_q,      a_d;
    logic [31:0] mag_q,    mag_d;
    logic [7:0]  exp_q,    exp_d;
    logic        sign_q,   sign_d;
    logic [23:0] man_q,    man_d;
    logic        guard_q,  guard_d;
    logic        round_q,  round_d;
    logic        sticky_q, sticky_d;
    logic [31:0] z_q,      z_d;
    logic        z_stb_q,  z_stb_d;
    logic        a_ack_q,  a_ack_d;

    assign input_a_ack  = a_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;

    // Next-state and datapath update for every conversion step
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        man_d    = man_q;
        guard_d  = guard_q;
        round_d  = round_q;
        sticky_d = sticky_q;
        z_d      = z_q;
        z_stb_d  = z_stb_q;
        a_ack_d  = a_ack_q;

        case (state_q)
            GET_A: begin
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    state_d = CONVERT_0;
                end else begin
                    a_ack_d = 1'b1;
                end
            end
            CONVERT_0: begin
                if (a_q == '0) begin
                    sign_d  = 1'b0;
                    // -127 modulo 256, so the packed biased exponent is 0
                    exp_d   = 8'h81;
                    man_d   = '0;
                    state_d = PACK;
                end else begin
                    sign_d  = a_q[31];
                    // 0x80000000 negates to itself, which is the correct magnitude
                    mag_d   = a_q[31] ? (~a_q + 32'd1) : a_q;
                    exp_d   = 8'd31;
                    state_d = NORMALISE;
                end
            end
            NORMALISE: begin
                if (mag_q[31]) begin
                    state_d = EXTRACT;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end
            end
            EXTRACT: begin
                man_d    = mag_q[31:8];
                guard_d  = mag_q[7];
                round_d  = mag_q[6];
                sticky_d = |mag_q[5:0];
                state_d  = ROUND;
            end
            ROUND: begin
                if (guard_q && (round_q || sticky_q || man_q[0])) begin
                    man_d = man_q + 24'd1;
                    if (man_q == '1) begin
                        exp_d = exp_q + 8'd1;
                    end
                end
                state_d = PACK;
            end
            PACK: begin
                z_d     = {sign_q, exp_q + 8'd127, man_q[22:0]};
                z_stb_d = 1'b1;
                state_d = PUT_Z;
            end
            PUT_Z: begin
                if (z_stb_q && output_z_ack) begin
                    z_stb_d = 1'b0;
                    a_ack_d = 1'b1;
                    state_d = GET_A;
                end
            end
            default: begin
                state_d = GET_A;
                a_ack_d = 1'b0;
                z_stb_d = 1'b0;
            end
        endcase
    end

    // State registers; reset wins over any other update in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= GET_A;
            a_q      <= '0;
            mag_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            man_q    <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            z_q      <= '0;
            z_stb_q  <= 1'b0;
            a_ack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            man_q    <= man_d;
            guard_q  <= guard_d;
            round_q  <= round_d;
            sticky_q <= sticky_d;
            z_q      <= z_d;
            z_stb_q  <= z_stb_d;
            a_ack_q  <= a_ack_d;
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Testbench for int_to_float: directed corner cases, backpressure, reset
// abort and randomized operands compared against an arithmetic reference.
`timescale 1ns/1ps
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int n_checks = 0;
    int n_errors = 0;

    int_to_float dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: integer magnitude, msb position, remainder-based RNE rounding
    function automatic void model(input logic [31:0] a, output logic [31:0] z, output int lat);
        longint m, q, rem, half;
        int p, sh;
        logic s;
        if (a == 32'd0) begin
            z   = 32'd0;
            lat = 3;
            return;
        end
        s = a[31];
        m = s ? ((longint'(1) << 32) - longint'(a)) : longint'(a);
        p = 0;
        for (int i = 0; i < 32; i++)
            if (((m >> i) & 1) != 0) p = i;
        lat = (31 - p) + 6;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        z = {s, 8'(p + 127), q[22:0]};
    endfunction

    // One full transaction; use_ref selects fixed expectations over the model
    task automatic run_op(input logic [31:0] a, input int pre, input int stall,
                          input bit use_ref, input logic [31:0] ref_z, input int ref_lat);
        logic [31:0] exp_z;
        int exp_lat;
        int n;
        if (use_ref) begin
            exp_z   = ref_z;
            exp_lat = ref_lat;
        end else begin
            model(a, exp_z, exp_lat);
        end
        n = 0;
        while (!input_a_ack && n < 100) begin
            step();
            n++;
        end
        check("ack_wait", 32'(input_a_ack), 32'd1);
        if (!input_a_ack) return;
        repeat (pre) step();
        input_a     = a;
        input_a_stb = 1'b1;
        step();
        n = 1;
        while (!output_z_stb && n < 200) begin
            input_a     = $urandom;
            input_a_stb = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        input_a_stb = 1'b0;
        check("stb_wait", 32'(output_z_stb), 32'd1);
        check("latency", 32'(n), 32'(exp_lat));
        check("result", output_z, exp_z);
        repeat (stall) begin
            input_a = $urandom;
            step();
            check("hold_z", output_z, exp_z);
            check("hold_stb", 32'(output_z_stb), 32'd1);
            check("ack_low", 32'(input_a_ack), 32'd0);
        end
        output_z_ack = 1'b1;
        step();
        output_z_ack = 1'b0;
        check("stb_drop", 32'(output_z_stb), 32'd0);
        check("ack_back", 32'(input_a_ack), 32'd1);
        check("z_keep", output_z, exp_z);
    endtask

    initial begin
        logic [31:0] a;
        int seen_stb;
        rst          = 1'b1;
        input_a      = '0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        @(negedge clk);
        step();
        check("rst_ack", 32'(input_a_ack), 32'd0);
        check("rst_stb", 32'(output_z_stb), 32'd0);
        check("rst_z", output_z, 32'd0);
        rst = 1'b0;
        step();
        check("ack_after_rst", 32'(input_a_ack), 32'd1);

        // Directed corner cases with fixed expected results and latencies
        run_op(32'h00000001, 0, 0, 1'b1, 32'h3F800000, 37);
        run_op(32'hFFFFFFFF, 1, 0, 1'b1, 32'hBF800000, 37);
        run_op(32'h00000000, 0, 0, 1'b1, 32'h00000000, 3);
        run_op(32'h80000000, 0, 0, 1'b1, 32'hCF000000, 6);
        run_op(32'h7FFFFFFF, 0, 0, 1'b1, 32'h4F000000, 7);
        run_op(32'h01000001, 0, 0, 1'b1, 32'h4B800000, 13);
        run_op(32'h01000003, 0, 0, 1'b1, 32'h4B800002, 13);
        // Backpressure: consumer stalls 10 cycles
        run_op(32'h00001234, 2, 10, 1'b1, 32'h4591A000, 25);

        // Reset during NORMALISE discards the conversion
        input_a     = 32'h00000001;
        input_a_stb = 1'b1;
        step();
        input_a_stb = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_ack0", 32'(input_a_ack), 32'd0);
        check("abort_stb0", 32'(output_z_stb), 32'd0);
        step();
        check("abort_ack1", 32'(input_a_ack), 32'd1);
        seen_stb = 0;
        repeat (40) begin
            step();
            if (output_z_stb) seen_stb++;
        end
        check("abort_no_stb", 32'(seen_stb), 32'd0);
        run_op(32'h00000005, 0, 0, 1'b1, 32'h40A00000, 35);

        // Randomized operands of varied magnitude with stb/ack stalls
        for (int i = 0; i < 200; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) a = -a;
            if (i % 50 == 0) a = 32'h80000000 >> (i / 50);
            run_op(a, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, 32'd0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
